// File: rtl/ram_checker.sv
// ram_checker
// Read-back checker for a RAM that was preloaded with the pattern
// data = (address + OFFSET) mod 2**DATA_W. One start pulse sweeps every
// address once, compares each returned word against the pattern and
// reports the mismatch count, the first failing address and an overall
// pass flag.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle request to begin a pass (honoured only when idle)
//   q_in           RAM read data, valid RD_LAT cycles after addr_out
//   addr_out       RAM address
//   wren           RAM write enable, tied low (read only)
//   busy           high while addresses are issued or read data is draining
//   done           one-cycle pulse at the end of a pass
//   pass           last completed pass had zero mismatches
//   err_cnt        mismatch count of the current / last pass
//   first_err_addr address of the first mismatch of the current / last pass
module ram_checker #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int OFFSET = 0,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] q_in,
   output logic [ADDR_W-1:0] addr_out,
   output logic              wren,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
   localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);
   localparam logic [DATA_W-1:0] OFFSET_T   = DATA_W'(OFFSET);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        drain_q, drain_d;
   logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic              pass_q, pass_d;

   // Address tag pipeline: stage RD_LAT-1 lines up with the word on q_in.
   logic [RD_LAT-1:0] vld_q;
   logic [ADDR_W-1:0] tag_q [RD_LAT];

   logic              cmp_vld;
   logic [ADDR_W-1:0] cmp_addr;
   logic [DATA_W-1:0] cmp_exp;
   logic              mismatch;

   assign cmp_vld  = vld_q[RD_LAT-1];
   assign cmp_addr = tag_q[RD_LAT-1];
   // Size cast zero-extends or truncates the address to the data width;
   // the add then wraps naturally modulo 2**DATA_W.
   assign cmp_exp  = DATA_W'(cmp_addr) + OFFSET_T;
   assign mismatch = cmp_vld && (q_in != cmp_exp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         // Only addresses issued in READ are tagged valid, so the address
         // held during DRAIN is never compared a second time.
         vld_q[0] <= (state_q == READ);
         tag_q[0] <= addr_q;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      drain_d   = drain_q;
      err_cnt_d = err_cnt_q;
      first_d   = first_q;
      pass_d    = pass_q;

      // Compares run independently of the state; the pipeline is empty
      // whenever IDLE could clear the counters, so there is no conflict.
      if (mismatch) begin
         err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
         if (err_cnt_q == '0) begin
            first_d = cmp_addr;
         end
      end

      case (state_q)
         IDLE: begin
            addr_d = '0;
            if (start) begin
               state_d   = READ;
               err_cnt_d = '0;
               first_d   = '0;
               pass_d    = 1'b0;
            end
         end
         READ: begin
            if (addr_q == LAST_ADDR) begin
               state_d = DRAIN;
               drain_d = '0;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = DONE;
               addr_d  = '0;
               // Use the next-state count so the final compare is included.
               pass_d  = (err_cnt_d == '0);
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         drain_q   <= '0;
         err_cnt_q <= '0;
         first_q   <= '0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         drain_q   <= drain_d;
         err_cnt_q <= err_cnt_d;
         first_q   <= first_d;
         pass_q    <= pass_d;
      end
   end

   assign addr_out       = addr_q;
   assign wren           = 1'b0;
   assign busy           = (state_q == READ) || (state_q == DRAIN);
   assign done           = (state_q == DONE);
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_q;

endmodule

// File: tb/tb_ram_checker.sv
// Testbench for ram_checker. Two checker instances run side by side:
// instance 0 with default parameters, instance 1 with RD_LAT=2, OFFSET=5.
// Each has its own RAM model holding its expected pattern XOR a shared
// per-address corruption mask, so both must report identical results.
module tb_ram_checker;

   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int DEPTH = 256;

   typedef struct {
      int st;
      int errs;
      int first;
      bit pass;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;

   logic [1:0]    busy_w, done_w, pass_w, wren_w;
   logic [AW:0]   err_w   [2];
   logic [AW-1:0] addr_w  [2];
   logic [AW-1:0] first_w [2];

   logic [DW-1:0] flip [DEPTH];
   rec_t          exp_q [2][$];

   int cyc   = 0;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int LAT = (gi == 0) ? 1 : 2;
      localparam int OFF = (gi == 0) ? 0 : 5;

      logic [DW-1:0] pipe [LAT];

      // Synchronous-read RAM model with LAT cycles of latency.
      always @(posedge clk) begin
         for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
         pipe[0] <= DW'((int'(addr_w[gi]) + OFF) % 256) ^ flip[addr_w[gi]];
      end

      ram_checker #(
         .ADDR_W(AW), .DATA_W(DW), .OFFSET(OFF), .RD_LAT(LAT)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .start         (start),
         .q_in          (pipe[LAT-1]),
         .addr_out      (addr_w[gi]),
         .wren          (wren_w[gi]),
         .busy          (busy_w[gi]),
         .done          (done_w[gi]),
         .pass          (pass_w[gi]),
         .err_cnt       (err_w[gi]),
         .first_err_addr(first_w[gi])
      );

      // Monitor: tracks the issued address sequence and busy length, and
      // on every done pulse pops the next expected result and compares.
      initial begin
         int   seq_n = 0, busy_n = 0;
         bit   seq_bad = 0, wren_bad = 0, pbusy_bad = 0, chk_next = 0;
         rec_t cur;
         forever begin
            @(negedge clk);
            if (rst) begin
               seq_n = 0; busy_n = 0; seq_bad = 0; pbusy_bad = 0; chk_next = 0;
            end else begin
               if (wren_w[gi] !== 1'b0) wren_bad = 1;
               if (chk_next) begin
                  check($sformatf("i%0d done_width", gi), done_w[gi], 0);
                  check($sformatf("i%0d pass_held", gi), pass_w[gi], cur.pass);
                  chk_next = 0;
               end
               if (busy_w[gi] === 1'b1) begin
                  if (seq_n < DEPTH && addr_w[gi] !== AW'(seq_n)) seq_bad = 1;
                  if (pass_w[gi] !== 1'b0) pbusy_bad = 1;
                  seq_n++;
                  busy_n++;
               end
               if (done_w[gi] === 1'b1) begin
                  if (exp_q[gi].size() == 0) begin
                     tests++;
                     fails++;
                     $display("FAIL i%0d unexpected_done: got done=1 at cycle %0d required no done", gi, cyc);
                  end else begin
                     cur = exp_q[gi].pop_front();
                     check($sformatf("i%0d latency", gi), cyc, cur.st + DEPTH + LAT + 1);
                     check($sformatf("i%0d err_cnt", gi), err_w[gi], cur.errs);
                     check($sformatf("i%0d first_err_addr", gi), first_w[gi], cur.first);
                     check($sformatf("i%0d pass", gi), pass_w[gi], cur.pass);
                     check($sformatf("i%0d busy_at_done", gi), busy_w[gi], 0);
                     check($sformatf("i%0d busy_cycles", gi), busy_n, DEPTH + LAT);
                     check($sformatf("i%0d addr_sequence_bad", gi), seq_bad, 0);
                     check($sformatf("i%0d pass_low_while_busy_bad", gi), pbusy_bad, 0);
                     check($sformatf("i%0d wren_bad", gi), wren_bad, 0);
                     chk_next = 1;
                  end
                  seq_n = 0; busy_n = 0; seq_bad = 0; pbusy_bad = 0;
               end
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s i%0d busy", tag, i), busy_w[i], 0);
         check($sformatf("%s i%0d done", tag, i), done_w[i], 0);
         check($sformatf("%s i%0d pass", tag, i), pass_w[i], 0);
         check($sformatf("%s i%0d wren", tag, i), wren_w[i], 0);
         check($sformatf("%s i%0d err_cnt", tag, i), err_w[i], 0);
         check($sformatf("%s i%0d first_err_addr", tag, i), first_w[i], 0);
         check($sformatf("%s i%0d addr_out", tag, i), addr_w[i], 0);
      end
   endtask

   // Reference model: a pass reports how many locations are corrupted,
   // the lowest corrupted address, and pass when none are.
   task automatic push_expected(input int st);
      rec_t r;
      r.st = st;
      r.errs = 0;
      r.first = 0;
      for (int a = DEPTH - 1; a >= 0; a--) begin
         if (flip[a] != 0) begin
            r.errs++;
            r.first = a;
         end
      end
      r.pass = (r.errs == 0);
      exp_q[0].push_back(r);
      exp_q[1].push_back(r);
      $display("[TB] pass start cycle %0d: expect err_cnt=%0d first=%0d pass=%0d", st, r.errs, r.first, r.pass);
   endtask

   task automatic wait_empty();
      for (int k = 0; k < 400 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); k++) @(negedge clk);
      if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
         check("done_timeout", 1, 0);
         exp_q[0].delete();
         exp_q[1].delete();
      end
   endtask

   // repulse_at / rst_at: cycle after start at which to re-pulse start or
   // assert reset; 0 disables.
   task automatic run_pass(input int repulse_at, input int rst_at);
      int last;
      last = (repulse_at > rst_at) ? repulse_at : rst_at;
      if (last < 1) last = 1;
      @(negedge clk);
      start = 1'b1;
      if (rst_at == 0) push_expected(cyc);
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         start = (c == repulse_at);
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            check_zero("mid_pass_reset");
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      @(negedge clk);
      start = 1'b0;
      wait_empty();
      repeat (3) @(negedge clk);
   endtask

   task automatic fill_sparse();
      for (int a = 0; a < DEPTH; a++)
         flip[a] = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(1, 255)) : '0;
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) flip[a] = '0;

      // Reset, with start held high during reset to confirm it is ignored.
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      #1;
      check_zero("reset");
      repeat (2) @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("after_reset");

      // Clean RAM.
      run_pass(0, 0);

      // Two corrupted locations (0x10 and 0x80).
      flip[8'h10] = 8'hEF;
      flip[8'h80] = 8'h80;
      run_pass(0, 0);

      // Every location corrupted: full-depth count.
      for (int a = 0; a < DEPTH; a++) flip[a] = DW'($urandom_range(1, 255));
      run_pass(0, 0);

      // Start re-pulsed mid-pass must be ignored.
      fill_sparse();
      run_pass(50, 0);

      // Reset mid-pass aborts with no done, then a fresh pass.
      fill_sparse();
      run_pass(0, 100);
      repeat (300) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("post_abort i%0d busy", i), busy_w[i], 0);
         check($sformatf("post_abort i%0d err_cnt", i), err_w[i], 0);
      end
      run_pass(0, 0);

      // Randomized passes.
      for (int n = 0; n < 3; n++) begin
         fill_sparse();
         run_pass(0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
